// File: rtl/spi_txn_arbiter_if.sv
// Bundle of requester-side and SPI-controller-side signals around spi_txn_arbiter.
// The arbiter takes the slave view; client logic plus controller take the master view.
interface spi_txn_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*8-1:0]     tx_data;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       tx_ack;
  logic [7:0]               rx_data;
  logic [NUM_REQ-1:0]       rx_valid;
  logic [NUM_REQ-1:0]       txn_done;
  logic                     spi_start;
  logic [7:0]               spi_data_to_send;
  logic                     spi_hold_cs;
  logic                     spi_busy;
  logic                     spi_done;
  logic [7:0]               spi_data_received;

  modport master (
    output req, req_len, tx_data, spi_busy, spi_done, spi_data_received,
    input  grant, tx_ack, rx_data, rx_valid, txn_done,
           spi_start, spi_data_to_send, spi_hold_cs
  );

  modport slave (
    input  req, req_len, tx_data, spi_busy, spi_done, spi_data_received,
    output grant, tx_ack, rx_data, rx_valid, txn_done,
           spi_start, spi_data_to_send, spi_hold_cs
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI controller between NUM_REQ requesters,
// chaining each multi-byte transaction under a single CS assertion via hold_cs.
module spi_txn_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_txn_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    XFER,
    DRAIN,
    RELEASE
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   winner_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [LEN_W-1:0]   remaining_reg;
  logic [7:0]         byte_reg;
  logic [7:0]         rx_data_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [NUM_REQ-1:0] tx_ack_reg;
  logic [NUM_REQ-1:0] rx_valid_reg;
  logic [NUM_REQ-1:0] txn_done_reg;
  logic               spi_start_reg;

  logic [LEN_W-1:0]   len_sel [NUM_REQ];
  logic [7:0]         tx_sel  [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [NUM_REQ-1:0] winner_onehot;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign len_sel[gi]  = bus.req_len[gi*LEN_W +: LEN_W];
      assign tx_sel[gi]   = bus.tx_data[gi*8 +: 8];
      assign eligible[gi] = bus.req[gi] && (len_sel[gi] != '0);
    end
  endgenerate

  // Scan from farthest to nearest so the first eligible after the pointer wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_idx = IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (eligible[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign pick_onehot   = NUM_REQ'(1) << pick_idx;
  assign winner_onehot = NUM_REQ'(1) << winner_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      winner_reg    <= '0;
      rr_ptr_reg    <= IDX_W'(NUM_REQ - 1);
      remaining_reg <= '0;
      byte_reg      <= '0;
      rx_data_reg   <= '0;
      grant_reg     <= '0;
      tx_ack_reg    <= '0;
      rx_valid_reg  <= '0;
      txn_done_reg  <= '0;
      spi_start_reg <= 1'b0;
    end else begin
      spi_start_reg <= 1'b0;
      tx_ack_reg    <= '0;
      rx_valid_reg  <= '0;
      txn_done_reg  <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            winner_reg    <= pick_idx;
            remaining_reg <= len_sel[pick_idx];
            byte_reg      <= tx_sel[pick_idx];
            grant_reg     <= pick_onehot;
            tx_ack_reg    <= pick_onehot;
            spi_start_reg <= 1'b1;
            state_reg     <= LAUNCH;
          end
        end
        LAUNCH: state_reg <= XFER;
        XFER: begin
          if (bus.spi_done) begin
            rx_data_reg   <= bus.spi_data_received;
            rx_valid_reg  <= winner_onehot;
            remaining_reg <= remaining_reg - LEN_W'(1);
            // Next byte must be on data_to_send the cycle after done so the chain holds CS.
            if (remaining_reg > LEN_W'(1)) begin
              byte_reg   <= tx_sel[winner_reg];
              tx_ack_reg <= winner_onehot;
            end else begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!bus.spi_busy) begin
            grant_reg    <= '0;
            txn_done_reg <= winner_onehot;
            state_reg    <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr_reg <= winner_reg;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant            = grant_reg;
  assign bus.tx_ack           = tx_ack_reg;
  assign bus.rx_data          = rx_data_reg;
  assign bus.rx_valid         = rx_valid_reg;
  assign bus.txn_done         = txn_done_reg;
  assign bus.spi_start        = spi_start_reg;
  assign bus.spi_data_to_send = byte_reg;
  assign bus.spi_hold_cs      = (remaining_reg > LEN_W'(1));
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a loopback SPI controller model and requester byte feeders.
module tb_spi_txn_arbiter;
  localparam int NR = 3;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_txn_arbiter_if #(.NUM_REQ(NR), .LEN_W(LW)) bus ();

  spi_txn_arbiter #(.NUM_REQ(NR), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  tb_bytes [NR][16];
  int          ack_cnt  [NR];
  int          ack_tot  [NR];
  logic        hold_log [$];
  logic [15:0] rx_log   [$];
  int          done_cnt [NR];
  int          grant_order [$];
  int          start_cnt, multihot_cnt, grant2_cnt, min_gap, low_run;
  bit          seen_grant;
  int          inject_req = 0;
  int          inject_seen;

  // Each requester presents its next listed byte; the list index advances on tx_ack.
  always_comb begin
    bus.tx_data = '0;
    for (int i = 0; i < NR; i++) bus.tx_data[i*8 +: 8] = tb_bytes[i][ack_cnt[i] & 15];
  end

  // Loopback controller: 3-cycle bytes, chains while hold_cs, busy lingers one cycle at the end.
  initial begin : env
    int c_cnt;
    logic c_act, c_next, c_tail;
    logic [7:0] c_byte;
    c_cnt = 0; c_act = 0; c_next = 0; c_tail = 0; c_byte = '0; inject_seen = 0;
    bus.spi_busy = 1'b0; bus.spi_done = 1'b0; bus.spi_data_received = '0;
    for (int i = 0; i < NR; i++) begin ack_cnt[i] = 0; ack_tot[i] = 0; end
    forever begin
      @(negedge clk);
      bus.spi_done = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (!rst_n || bus.txn_done[i]) ack_cnt[i] = 0;
        else if (bus.tx_ack[i]) begin ack_cnt[i]++; ack_tot[i]++; end
      end
      if (!rst_n) begin
        c_act = 0; c_next = 0; c_tail = 0; bus.spi_busy = 1'b0;
      end else if (c_next) begin
        c_next = 0; c_byte = bus.spi_data_to_send; c_cnt = 3;
      end else if (c_tail) begin
        c_tail = 0; c_act = 0; bus.spi_busy = 1'b0;
      end else if (c_act) begin
        if (c_cnt > 1) c_cnt--;
        else begin
          bus.spi_done = 1'b1;
          bus.spi_data_received = c_byte;
          hold_log.push_back(bus.spi_hold_cs);
          if (bus.spi_hold_cs) c_next = 1; else c_tail = 1;
        end
      end else if (inject_seen != inject_req) begin
        inject_seen = inject_req;
        bus.spi_done = 1'b1;
        bus.spi_data_received = 8'hEE;
      end else if (bus.spi_start) begin
        c_act = 1; bus.spi_busy = 1'b1; c_byte = bus.spi_data_to_send; c_cnt = 3;
      end
    end
  end

  initial begin : mon
    start_cnt = 0; multihot_cnt = 0; grant2_cnt = 0; min_gap = 1000; low_run = 0; seen_grant = 0;
    for (int i = 0; i < NR; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (bus.rx_valid[i]) rx_log.push_back({8'(i), bus.rx_data});
        if (bus.txn_done[i]) begin
          done_cnt[i]++;
          $display("[%0t] txn done: requester %0d, completed txns %0d", $time, i, done_cnt[i]);
        end
      end
      if (bus.spi_start) begin
        start_cnt++;
        for (int i = 0; i < NR; i++) if (bus.grant[i]) grant_order.push_back(i);
      end
      if ($countones(bus.grant) > 1) multihot_cnt++;
      if (bus.grant[2]) grant2_cnt++;
      if (bus.grant == '0) low_run++;
      else begin
        if (seen_grant && low_run > 0 && low_run < min_gap) min_gap = low_run;
        low_run = 0;
        seen_grant = 1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int i, input int v);
    bus.req_len[i*LW +: LW] = LW'(v);
  endtask

  task automatic wait_done(input int idx, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (bus.txn_done[idx]) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  function automatic int rx_count(input int i);
    int c = 0;
    foreach (rx_log[k]) if (int'(rx_log[k][15:8]) == i) c++;
    return c;
  endfunction

  function automatic logic [31:0] rx_nth(input int i, input int n);
    int c = 0;
    foreach (rx_log[k]) begin
      if (int'(rx_log[k][15:8]) == i) begin
        if (c == n) return {24'b0, rx_log[k][7:0]};
        c++;
      end
    end
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] hold_at(input int k);
    if (k < hold_log.size()) return 32'(hold_log[k]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] order_at(input int k);
    if (k < grant_order.size()) return 32'(grant_order[k]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin : main
    int base, rb, hb, ab, db, sb, g2, ndone;
    logic seen;
    for (int i = 0; i < NR; i++) for (int k = 0; k < 16; k++) tb_bytes[i][k] = 8'h00;
    bus.req = '0;
    bus.req_len = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_start", 32'(bus.spi_start), 32'd0);
    chk("rst_hold", 32'(bus.spi_hold_cs), 32'd0);
    chk("rst_data_to_send", 32'(bus.spi_data_to_send), 32'd0);
    chk("rst_pulses", 32'({bus.tx_ack, bus.rx_valid, bus.txn_done}), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte from requester 0
    tb_bytes[0][0] = 8'hA5;
    set_len(0, 1);
    bus.req = 3'b001;
    @(negedge clk);
    chk("t1_start", 32'(bus.spi_start), 32'd1);
    chk("t1_grant", 32'(bus.grant), 32'b001);
    chk("t1_tx_ack", 32'(bus.tx_ack), 32'b001);
    chk("t1_hold", 32'(bus.spi_hold_cs), 32'd0);
    chk("t1_data", 32'(bus.spi_data_to_send), 32'hA5);
    bus.req = '0;
    wait_done(0, "t1");
    chk("t1_release_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    chk("t1_rx_count", 32'(rx_count(0)), 32'd1);
    chk("t1_rx_byte", rx_nth(0, 0), 32'hA5);
    chk("t1_done_count", 32'(done_cnt[0]), 32'd1);

    // Reset while the pointer sits at 0; afterwards req0 must still win first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters held: strict alternation
    tb_bytes[0][0] = 8'h30; tb_bytes[0][1] = 8'h31; set_len(0, 2);
    tb_bytes[1][0] = 8'h40; set_len(1, 1);
    base = grant_order.size();
    rb = rx_count(0);
    bus.req = 3'b011;
    ndone = 0;
    for (int n = 0; n < 800 && ndone < 4; n++) begin
      @(negedge clk);
      if (bus.txn_done != '0) ndone++;
    end
    bus.req = '0;
    chk("t3_txn_count", 32'(ndone), 32'd4);
    repeat (2) @(negedge clk);
    chk("t3_order0", order_at(base), 32'd0);
    chk("t3_order1", order_at(base + 1), 32'd1);
    chk("t3_order2", order_at(base + 2), 32'd0);
    chk("t3_order3", order_at(base + 3), 32'd1);
    chk("t3_multihot", 32'(multihot_cnt), 32'd0);
    chk("t3_gap_ge2", 32'(min_gap >= 2), 32'd1);
    chk("t3_rx0_last", rx_nth(0, rb + 3), 32'h31);

    // Three chained bytes from requester 1
    tb_bytes[1][0] = 8'h11; tb_bytes[1][1] = 8'h22; tb_bytes[1][2] = 8'h33;
    set_len(1, 3);
    hb = hold_log.size(); rb = rx_count(1); ab = ack_tot[1]; db = done_cnt[1];
    bus.req = 3'b010;
    @(negedge clk);
    chk("t2_grant", 32'(bus.grant), 32'b010);
    chk("t2_hold_launch", 32'(bus.spi_hold_cs), 32'd1);
    chk("t2_data0", 32'(bus.spi_data_to_send), 32'h11);
    bus.req = '0;
    wait_done(1, "t2");
    @(negedge clk);
    chk("t2_ack_count", 32'(ack_tot[1] - ab), 32'd3);
    chk("t2_rx0", rx_nth(1, rb), 32'h11);
    chk("t2_rx1", rx_nth(1, rb + 1), 32'h22);
    chk("t2_rx2", rx_nth(1, rb + 2), 32'h33);
    chk("t2_hold0", hold_at(hb), 32'd1);
    chk("t2_hold1", hold_at(hb + 1), 32'd1);
    chk("t2_hold2", hold_at(hb + 2), 32'd0);
    chk("t2_done_count", 32'(done_cnt[1] - db), 32'd1);

    // Zero-length req2 ignored; req0 dropped and its length changed mid-transaction
    set_len(2, 0);
    tb_bytes[0][0] = 8'h5A; tb_bytes[0][1] = 8'h6B; set_len(0, 2);
    g2 = grant2_cnt; sb = start_cnt; rb = rx_count(0); db = done_cnt[0];
    bus.req = 3'b101;
    @(negedge clk);
    chk("t4_grant", 32'(bus.grant), 32'b001);
    bus.req = 3'b100;
    set_len(0, 7);
    wait_done(0, "t4");
    @(negedge clk);
    chk("t4_rx_count", 32'(rx_count(0) - rb), 32'd2);
    chk("t4_rx0", rx_nth(0, rb), 32'h5A);
    chk("t4_rx1", rx_nth(0, rb + 1), 32'h6B);
    chk("t4_done_count", 32'(done_cnt[0] - db), 32'd1);
    repeat (20) @(negedge clk);
    chk("t4_req2_never", 32'(grant2_cnt - g2), 32'd0);
    chk("t4_start_count", 32'(start_cnt - sb), 32'd1);
    bus.req = '0;

    // spi_done while idle is ignored
    rb = rx_log.size();
    inject_req++;
    repeat (4) @(negedge clk);
    chk("spur_rx_data", 32'(bus.rx_data), 32'h6B);
    chk("spur_rx_count", 32'(rx_log.size() - rb), 32'd0);
    chk("spur_grant", 32'(bus.grant), 32'd0);

    // Reset during byte 2 of a 4-byte transaction
    tb_bytes[1][0] = 8'h71; tb_bytes[1][1] = 8'h72; tb_bytes[1][2] = 8'h73; tb_bytes[1][3] = 8'h74;
    set_len(1, 4);
    db = done_cnt[1]; rb = rx_count(1);
    bus.req = 3'b010;
    @(negedge clk);
    chk("t5_grant", 32'(bus.grant), 32'b010);
    bus.req = '0;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (rx_count(1) == rb + 1) seen = 1'b1;
    end
    chk("t5_byte1_seen", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(bus.grant), 32'd0);
    chk("t5_rst_start", 32'(bus.spi_start), 32'd0);
    chk("t5_rst_pulses", 32'({bus.tx_ack, bus.rx_valid, bus.txn_done}), 32'd0);
    chk("t5_rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("t5_rst_data_to_send", 32'(bus.spi_data_to_send), 32'd0);
    chk("t5_rst_hold", 32'(bus.spi_hold_cs), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt[1] - db), 32'd0);
    tb_bytes[1][0] = 8'h99;
    set_len(1, 1);
    bus.req = 3'b010;
    @(negedge clk);
    chk("t5_fresh_grant", 32'(bus.grant), 32'b010);
    chk("t5_fresh_start", 32'(bus.spi_start), 32'd1);
    bus.req = '0;
    wait_done(1, "t5_fresh");
    @(negedge clk);
    chk("t5_fresh_rx", rx_nth(1, rx_count(1) - 1), 32'h99);
    chk("t5_fresh_done", 32'(done_cnt[1] - db), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
